// File: rtl/pack_pkg.sv
// Shared types and constants for the ping-pong buffer read scheduler.
package pack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADDR,
    ST_WAIT,
    ST_SEND
  } state_e;

  localparam logic [15:0] HDR_TAG_DFLT = 16'hA55A;
  localparam int          CNT_W        = 11;

  localparam logic [2:0] W_X   = 3'd0;
  localparam logic [2:0] W_Y   = 3'd1;
  localparam logic [2:0] W_Z   = 3'd2;
  localparam logic [2:0] W_UTC = 3'd3;
  localparam logic [2:0] W_NS  = 3'd4;

endpackage

// File: rtl/pack_rd_sched_if.sv
// 32-bit valid/ready frame stream from the scheduler to the packet framer.
interface pack_rd_sched_if;
  logic [31:0] pk_data;
  logic        pk_vld;
  logic        pk_rdy;
  logic        pk_sop;
  logic        pk_eop;

  modport master (output pk_data, pk_vld, pk_sop, pk_eop, input pk_rdy);
  modport slave  (input pk_data, pk_vld, pk_sop, pk_eop, output pk_rdy);
endinterface

// File: rtl/pack_word_mux.sv
// Holding registers for one sample plus the registered stream word (header or sample word).
module pack_word_mux
  import pack_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        hdr_ld,
  input  logic        q_ld,
  input  logic        adv,
  input  logic [2:0]  sel,
  input  logic [31:0] hdr,
  input  logic [31:0] q_x,
  input  logic [31:0] q_y,
  input  logic [31:0] q_z,
  input  logic [31:0] q_utc,
  input  logic [31:0] q_ns,
  output logic [31:0] word
);

  logic [31:0] hold_q [5];
  logic [31:0] hold_d [5];
  logic [31:0] word_q, word_d;

  always_comb begin
    for (int i = 0; i < 5; i++) hold_d[i] = hold_q[i];
    word_d = word_q;
    if (q_ld) begin
      hold_d[0] = q_x;
      hold_d[1] = q_y;
      hold_d[2] = q_z;
      hold_d[3] = q_utc;
      hold_d[4] = q_ns;
    end
    if (hdr_ld) begin
      word_d = hdr;
    end else if (q_ld) begin
      word_d = q_x;
    end else if (adv) begin
      case (sel)
        W_X:     word_d = hold_q[0];
        W_Y:     word_d = hold_q[1];
        W_Z:     word_d = hold_q[2];
        W_UTC:   word_d = hold_q[3];
        W_NS:    word_d = hold_q[4];
        default: word_d = word_q;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < 5; i++) hold_q[i] <= hold_d[i];
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) word_q <= '0;
    else        word_q <= word_d;
  end

  assign word = word_q;

endmodule

// File: rtl/pack_rd_sched.sv
// Walks a closed buffer half sample by sample and serialises X/Y/Z/UTC/NS behind a frame header.
module pack_rd_sched
  import pack_pkg::*;
#(
  parameter int          RD_LAT  = 2,
  parameter logic [15:0] HDR_TAG = HDR_TAG_DFLT
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   syn_vld,
  input  logic [11:0]            buf_waddr,
  output logic [11:0]            buf_raddr,
  input  logic [31:0]            q_x,
  input  logic [31:0]            q_y,
  input  logic [31:0]            q_z,
  input  logic [31:0]            q_utc,
  input  logic [31:0]            q_ns,
  pack_rd_sched_if.master        pk,
  output logic                   busy,
  output logic                   ovr_flag,
  input  logic                   ovr_clr,
  output logic [15:0]            frm_cnt
);

  state_e           state_q, state_d;
  logic             half_q, half_d, pend_half_q, pend_half_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, idx_q, idx_d, pend_cnt_q, pend_cnt_d;
  logic [2:0]       w_q, w_d, lat_q, lat_d;
  logic             pend_q, pend_d, ovr_q, ovr_d, busy_q, busy_d;
  logic             vld_q, vld_d, sop_q, sop_d, eop_q, eop_d;
  logic [15:0]      frm_q, frm_d;
  logic [11:0]      raddr_q, raddr_d;

  logic             fire, ovr_now, abort, go_hdr, hdr_ld, q_ld, adv;
  logic             nxt_half;
  logic [CNT_W-1:0] nxt_cnt;
  logic [31:0]      hdr_word;

  always_comb begin
    state_d = state_q;  half_d = half_q;  cnt_d = cnt_q;  idx_d = idx_q;
    w_d = w_q;  lat_d = lat_q;  pend_d = pend_q;
    pend_half_d = pend_half_q;  pend_cnt_d = pend_cnt_q;
    ovr_d = ovr_q;  frm_d = frm_q;  raddr_d = raddr_q;
    vld_d = vld_q;  sop_d = sop_q;  eop_d = eop_q;
    hdr_ld = 1'b0;  q_ld = 1'b0;  adv = 1'b0;  go_hdr = 1'b0;
    nxt_half = pend_half_q;
    nxt_cnt  = pend_cnt_q;
    fire     = vld_q && pk.pk_rdy;
    ovr_now  = syn_vld && (state_q != ST_IDLE);
    abort    = pend_q || ovr_now;

    if (ovr_clr) ovr_d = 1'b0;
    if (ovr_now) begin
      ovr_d       = 1'b1;
      pend_d      = 1'b1;
      pend_half_d = buf_waddr[11];
      pend_cnt_d  = buf_waddr[10:0];
      nxt_half    = buf_waddr[11];
      nxt_cnt     = buf_waddr[10:0];
    end
    // A word already carrying eop completes its frame even if an overrun is pending.
    if (fire && eop_q) frm_d = frm_q + 16'd1;

    case (state_q)
      ST_IDLE: if (syn_vld) begin
        go_hdr   = 1'b1;
        nxt_half = buf_waddr[11];
        nxt_cnt  = buf_waddr[10:0];
      end
      ST_HDR: if (fire) begin
        vld_d = 1'b0;  sop_d = 1'b0;  eop_d = 1'b0;
        if (abort)              go_hdr = 1'b1;
        else if (cnt_q == '0)   state_d = ST_IDLE;
        else begin
          state_d = ST_ADDR;
          idx_d   = '0;
          raddr_d = {half_q, 11'd0};
        end
      end
      ST_ADDR: begin
        state_d = ST_WAIT;
        lat_d   = 3'd1;
      end
      ST_WAIT: if (lat_q == 3'(RD_LAT)) begin
        state_d = ST_SEND;
        w_d     = W_X;
        q_ld    = 1'b1;
        vld_d   = 1'b1;
      end else begin
        lat_d = lat_q + 3'd1;
      end
      ST_SEND: if (fire) begin
        if (abort) begin
          go_hdr = 1'b1;
        end else if (w_q == W_NS) begin
          vld_d = 1'b0;
          eop_d = 1'b0;
          if (eop_q) state_d = ST_IDLE;
          else begin
            state_d = ST_ADDR;
            idx_d   = idx_q + 11'd1;
            raddr_d = {half_q, idx_q + 11'd1};
          end
        end else begin
          w_d   = w_q + 3'd1;
          adv   = 1'b1;
          eop_d = (w_q == W_UTC) && (idx_q == cnt_q - 11'd1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_hdr) begin
      state_d = ST_HDR;
      half_d  = nxt_half;
      cnt_d   = nxt_cnt;
      pend_d  = 1'b0;
      vld_d   = 1'b1;
      sop_d   = 1'b1;
      eop_d   = (nxt_cnt == '0);
      hdr_ld  = 1'b1;
    end
    hdr_word = {HDR_TAG, nxt_half, frm_d[3:0], nxt_cnt};
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;  half_q <= 1'b0;  cnt_q <= '0;  idx_q <= '0;
      w_q <= '0;  lat_q <= '0;  pend_q <= 1'b0;  pend_half_q <= 1'b0;
      pend_cnt_q <= '0;  ovr_q <= 1'b0;  frm_q <= '0;  raddr_q <= '0;
      vld_q <= 1'b0;  sop_q <= 1'b0;  eop_q <= 1'b0;  busy_q <= 1'b0;
    end else begin
      state_q <= state_d;  half_q <= half_d;  cnt_q <= cnt_d;  idx_q <= idx_d;
      w_q <= w_d;  lat_q <= lat_d;  pend_q <= pend_d;  pend_half_q <= pend_half_d;
      pend_cnt_q <= pend_cnt_d;  ovr_q <= ovr_d;  frm_q <= frm_d;  raddr_q <= raddr_d;
      vld_q <= vld_d;  sop_q <= sop_d;  eop_q <= eop_d;  busy_q <= busy_d;
    end
  end

  pack_word_mux u_word_mux (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .hdr_ld  (hdr_ld),
    .q_ld    (q_ld),
    .adv     (adv),
    .sel     (w_d),
    .hdr     (hdr_word),
    .q_x     (q_x),
    .q_y     (q_y),
    .q_z     (q_z),
    .q_utc   (q_utc),
    .q_ns    (q_ns),
    .word    (pk.pk_data)
  );

  assign pk.pk_vld = vld_q;
  assign pk.pk_sop = sop_q;
  assign pk.pk_eop = eop_q;
  assign buf_raddr = raddr_q;
  assign busy      = busy_q;
  assign ovr_flag  = ovr_q;
  assign frm_cnt   = frm_q;

endmodule

// File: tb/tb_pack_rd_sched.sv
// Directed bench for pack_rd_sched: address-tagged RAM model, stream recorder and expected-frame builder.
module tb_pack_rd_sched;

  localparam int RD_LAT = 2;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        syn_vld = 1'b0;
  logic        ovr_clr = 1'b0;
  logic [11:0] buf_waddr = '0;
  logic [11:0] buf_raddr;
  logic [31:0] q_x, q_y, q_z, q_utc, q_ns;
  logic        busy, ovr_flag;
  logic [15:0] frm_cnt;

  pack_rd_sched_if pk_if ();

  pack_rd_sched #(.RD_LAT(RD_LAT), .HDR_TAG(16'hA55A)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .syn_vld   (syn_vld),
    .buf_waddr (buf_waddr),
    .buf_raddr (buf_raddr),
    .q_x       (q_x),
    .q_y       (q_y),
    .q_z       (q_z),
    .q_utc     (q_utc),
    .q_ns      (q_ns),
    .pk        (pk_if),
    .busy      (busy),
    .ovr_flag  (ovr_flag),
    .ovr_clr   (ovr_clr),
    .frm_cnt   (frm_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM model: data returns RD_LAT cycles after the address, tagged by word kind and address.
  logic [11:0] ap [RD_LAT];
  always @(posedge clk_sys) begin
    ap[0] <= buf_raddr;
    for (int i = 1; i < RD_LAT; i++) ap[i] <= ap[i-1];
  end
  assign q_x   = {4'h1, 16'h0, ap[RD_LAT-1]};
  assign q_y   = {4'h2, 16'h0, ap[RD_LAT-1]};
  assign q_z   = {4'h3, 16'h0, ap[RD_LAT-1]};
  assign q_utc = {4'h4, 16'h0, ap[RD_LAT-1]};
  assign q_ns  = {4'h5, 16'h0, ap[RD_LAT-1]};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream entries are {sop, eop, data}.
  logic [33:0] obs_q[$];
  logic [33:0] exp_q[$];
  int          rdy_mode = 1;
  logic        stall_p = 1'b0;
  logic [33:0] last_p = '0;

  always @(negedge clk_sys) begin
    bit r;
    if (!rst_n) begin
      stall_p = 1'b0;
      pk_if.pk_rdy = 1'b0;
    end else begin
      if (stall_p)
        chk("stall hold", 64'({pk_if.pk_vld, pk_if.pk_sop, pk_if.pk_eop, pk_if.pk_data}),
            64'({1'b1, last_p}));
      r = (rdy_mode == 2) ? ($urandom_range(0, 99) >= 30) : (rdy_mode == 1);
      pk_if.pk_rdy = r;
      if (pk_if.pk_vld && r) obs_q.push_back({pk_if.pk_sop, pk_if.pk_eop, pk_if.pk_data});
      stall_p = pk_if.pk_vld && !r;
      last_p  = {pk_if.pk_sop, pk_if.pk_eop, pk_if.pk_data};
    end
  end

  task automatic exp_hdr(input bit half, input logic [3:0] seq, input logic [10:0] cnt, input bit eop);
    exp_q.push_back({1'b1, eop, 16'hA55A, half, seq, cnt});
  endtask

  task automatic exp_word(input bit half, input logic [10:0] idx, input logic [3:0] k, input bit eop);
    exp_q.push_back({1'b0, eop, k, 16'h0, half, idx});
  endtask

  task automatic exp_frame(input bit half, input logic [3:0] seq, input logic [10:0] cnt);
    exp_hdr(half, seq, cnt, cnt == 11'd0);
    for (int i = 0; i < int'(cnt); i++)
      for (int k = 1; k <= 5; k++)
        exp_word(half, 11'(i), 4'(k), (i == int'(cnt) - 1) && (k == 5));
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    chk({tag, " len"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s w%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic sync(input logic [11:0] wa, input bit clr);
    buf_waddr = wa;
    syn_vld   = 1'b1;
    ovr_clr   = clr;
    @(negedge clk_sys);
    syn_vld   = 1'b0;
    ovr_clr   = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk_sys);
      n++;
    end
    chk("idle reached", 64'(busy), 64'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " vld/sop/eop"}, 64'({pk_if.pk_vld, pk_if.pk_sop, pk_if.pk_eop}), 64'(0));
    chk({tag, " data"}, 64'(pk_if.pk_data), 64'(0));
    chk({tag, " raddr"}, 64'(buf_raddr), 64'(0));
    chk({tag, " busy/ovr"}, 64'({busy, ovr_flag}), 64'(0));
    chk({tag, " frm_cnt"}, 64'(frm_cnt), 64'(0));
  endtask

  initial begin
    int  n;
    bit  found;

    repeat (3) @(negedge clk_sys);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk_sys);

    // Frame of 3 samples, ready always high, with latency checks.
    rdy_mode = 1;
    sync(12'h003, 1'b0);
    chk("f1 hdr flags", 64'({pk_if.pk_vld, pk_if.pk_sop, pk_if.pk_eop}), 64'(3'b110));
    chk("f1 hdr data", 64'(pk_if.pk_data), 64'(32'hA55A_0003));
    @(negedge clk_sys);
    n = 2;
    chk("f1 raddr T+2", 64'(buf_raddr), 64'(12'h000));
    while (!(pk_if.pk_vld && !pk_if.pk_sop) && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    chk("f1 first X latency", 64'(n), 64'(3 + RD_LAT));
    chk("f1 first X data", 64'(pk_if.pk_data), 64'(32'h1000_0000));
    exp_frame(1'b0, 4'd0, 11'd3);
    wait_idle(500);
    cmp_stream("f1");
    chk("f1 frm_cnt", 64'(frm_cnt), 64'(1));

    // Empty frame: header only, sop and eop together.
    sync(12'h800, 1'b0);
    chk("f2 hdr flags", 64'({pk_if.pk_vld, pk_if.pk_sop, pk_if.pk_eop}), 64'(3'b111));
    exp_frame(1'b1, 4'd1, 11'd0);
    wait_idle(50);
    cmp_stream("f2");
    chk("f2 frm_cnt", 64'(frm_cnt), 64'(2));

    // Upper half, 10 samples, random back-pressure.
    rdy_mode = 2;
    sync(12'h80A, 1'b0);
    exp_frame(1'b1, 4'd2, 11'd10);
    wait_idle(3000);
    rdy_mode = 1;
    cmp_stream("f3");
    chk("f3 frm_cnt", 64'(frm_cnt), 64'(3));

    // Overrun while Y of sample 4 is presented.
    sync(12'h00A, 1'b0);
    n = 0;
    while (!(pk_if.pk_vld && pk_if.pk_data == 32'h2000_0004) && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    chk("ovr trigger found", 64'(pk_if.pk_vld && pk_if.pk_data == 32'h2000_0004), 64'(1));
    sync(12'h005, 1'b0);
    chk("ovr hdr flags", 64'({pk_if.pk_vld, pk_if.pk_sop, pk_if.pk_eop}), 64'(3'b110));
    chk("ovr hdr data", 64'(pk_if.pk_data), 64'(32'hA55A_1805));
    chk("ovr flag set", 64'(ovr_flag), 64'(1));
    chk("ovr frm_cnt held", 64'(frm_cnt), 64'(3));
    exp_hdr(1'b0, 4'd3, 11'd10, 1'b0);
    for (int i = 0; i < 4; i++)
      for (int k = 1; k <= 5; k++) exp_word(1'b0, 11'(i), 4'(k), 1'b0);
    exp_word(1'b0, 11'd4, 4'd1, 1'b0);
    exp_word(1'b0, 11'd4, 4'd2, 1'b0);
    exp_frame(1'b0, 4'd3, 11'd5);
    wait_idle(500);
    cmp_stream("ovr");
    chk("ovr frm_cnt after", 64'(frm_cnt), 64'(4));

    ovr_clr = 1'b1;
    @(negedge clk_sys);
    ovr_clr = 1'b0;
    chk("ovr_clr alone", 64'(ovr_flag), 64'(0));

    // Overrun during WAIT with ovr_clr in the same cycle: set wins.
    sync(12'h004, 1'b0);
    repeat (2) @(negedge clk_sys);
    sync(12'h001, 1'b1);
    chk("ovr set beats clr", 64'(ovr_flag), 64'(1));
    exp_hdr(1'b0, 4'd4, 11'd4, 1'b0);
    exp_word(1'b0, 11'd0, 4'd1, 1'b0);
    exp_frame(1'b0, 4'd4, 11'd1);
    wait_idle(500);
    cmp_stream("ovr2");
    chk("ovr2 frm_cnt", 64'(frm_cnt), 64'(5));
    ovr_clr = 1'b1;
    @(negedge clk_sys);
    ovr_clr = 1'b0;
    chk("ovr_clr later", 64'(ovr_flag), 64'(0));

    // Reset in the middle of SEND.
    sync(12'h006, 1'b0);
    n = 0;
    while (obs_q.size() < 8 && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    chk("mid-send reached", 64'(pk_if.pk_vld && !pk_if.pk_sop), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    obs_q.delete();
    @(negedge clk_sys);
    sync(12'h002, 1'b0);
    chk("post-rst hdr data", 64'(pk_if.pk_data), 64'(32'hA55A_0002));
    exp_frame(1'b0, 4'd0, 11'd2);
    wait_idle(500);
    cmp_stream("postrst");
    chk("postrst frm_cnt", 64'(frm_cnt), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
